uart_rx_oversample: RTL and testbench
=====================================

// Module: uart_rx_oversample
// PURPOSE
//  Self-contained UART receiver: the far end of tx_fsm/piso/parity_gen framing (start, 8 data LSB-first,
//  optional parity, 1 stop). Samples RX_in on oversample ticks from baud_rate_generator (rx_enb), checks
//  parity and stop bit, and presents each byte through a valid/ready holding register. Replaces the
//  start_bit_detect_sync/sipo_simple/parity_check_simple/stop_check_simple/rx_fsm_simple cluster.
// PARAMETERS
//  DATA_BITS   8   data bits per frame
//  OVERSAMPLE  16  rx_enb ticks per bit period (even, >=4)
//  PARITY_EN   1   1 = parity bit present and checked
//  PARITY_ODD  0   0 = even parity (matches parity_gen), 1 = odd
// PORTS
//  clk          in   1          system clock
//  rst          in   1          async reset, active-high
//  RX_in        in   1          serial line, idle high, asynchronous to clk
//  rx_enb       in   1          oversample tick, 1-cycle pulse
//  RX_data_out  out  DATA_BITS  received byte, stable while data_ready=1
//  data_ready   out  1          holding register full
//  rx_ready     in   1          consumer accepts byte when data_ready&&rx_ready
//  parity_err   out  1          parity mismatch for the byte in the holding register
//  stop_err     out  1          stop bit sampled 0 for the byte in the holding register
//  overrun_err  out  1          1-cycle pulse: frame completed while holding register still full
//  RX_busy      out  1          FSM not in IDLE
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0, FSM IDLE, sync flops preset to 1, counters 0.
//  - RX_in passes through a 2-flop synchronizer; all decisions use the synchronized line rxs.
//  - tick_cnt (log2 OVERSAMPLE bits) advances only on rx_enb; bit_cnt counts data bits 0..DATA_BITS-1.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; STOP -> BREAK when stop bit reads 0.
//    IDLE:   rxs==0 on an rx_enb tick -> START, tick_cnt=0.
//    START:  at tick OVERSAMPLE/2-1 sample rxs; 0 -> DATA (tick_cnt=0), 1 -> IDLE (false start, no output).
//    DATA:   sample every OVERSAMPLE ticks (mid-bit); shift right, new bit into MSB (LSB-first);
//            after bit DATA_BITS-1 -> PARITY if PARITY_EN else STOP.
//    PARITY: sample at mid-bit; perr = sampled ^ (^shreg) ^ PARITY_ODD.
//    STOP:   sample at mid-bit; write holding register same cycle; rxs==1 -> IDLE, 0 -> BREAK.
//    BREAK:  wait for rxs==1 on an rx_enb tick, then IDLE; never produces further frames.
//  - Latency: data_ready rises on the clk after the rx_enb tick that samples the stop bit mid-point.
//    Return to IDLE at mid-stop allows back-to-back frames.
//  - Holding register write: RX_data_out<=shreg, parity_err<=perr, stop_err<=~rxs, data_ready<=1.
//  - Handshake: data_ready&&rx_ready clears data_ready, parity_err and stop_err next cycle.
//    RX_data_out keeps its last value.
//  - Overrun: write while data_ready && !rx_ready -> old byte and flags kept, new frame dropped,
//    overrun_err=1 for one cycle.
//  - Simultaneous write and accept in the same cycle: new byte loaded, data_ready stays 1, no overrun.
//  - rx_enb high every cycle is legal. rx_enb=0 freezes the FSM.
//  - Reset mid-frame aborts the partial byte. No output asserts until a fresh start bit arrives.
// STRUCTURE
//  - uart_pkg: typedef enum logic [2:0] {RX_IDLE,RX_START,RX_DATA,RX_PARITY,RX_STOP,RX_BREAK} rx_state_t;
//    localparam UART_DATA_BITS=8; localparam UART_OVERSAMPLE=16.
//  - Sub-module uart_sync2 (2-flop synchronizer, parameterised reset value) for RX_in.
//  - FSM, counters, shift register and holding register stay in this module.
// TESTING (OVERSAMPLE=16, rx_enb every 10 clk, bit = 160 clk, rx_ready=1 unless stated)
//  1. Frame 0xA5, parity 0, stop 1 -> one data_ready pulse, RX_data_out=A5, parity_err=0, stop_err=0.
//  2. RX_in low for 4 ticks then high -> RX_busy 1 then 0, data_ready never asserts.
//  3. Frame 0x3C with parity bit forced to 1 -> RX_data_out=3C, parity_err=1, stop_err=0.
//  4. Frame 0xF0 with stop=0, line held low 3 bit times -> one byte F0 with stop_err=1.
//     FSM stays in BREAK until high, then receives a following 0x81 correctly.
//  5. rx_ready=0, frames 0x11 then 0x22 -> RX_data_out stays 11, overrun_err pulses once.
//     Raising rx_ready clears data_ready next clk.
//  6. rst pulse during DATA bit 3 of 0x77 -> all outputs 0. Next frame 0x5A -> RX_data_out=5A, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, defaults and parity helper for the UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    // 1 when the received parity bit disagrees with the data. data_xor is the XOR of all data
    // bits; odd_mode flips the sense so a correct odd-parity frame also yields 0.
    function automatic logic parity_mismatch(input logic sampled_bit,
                                             input logic data_xor,
                                             input logic odd_mode);
        return sampled_bit ^ data_xor ^ odd_mode;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer with a selectable reset value
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to settle out of metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - oversampling UART receiver with parity/stop checks and holding register
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX_in,
    input  logic                 rx_enb,
    output logic [DATA_BITS-1:0] RX_data_out,
    output logic                 data_ready,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 stop_err,
    output logic                 overrun_err,
    output logic                 RX_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Start bit is checked half a bit after the falling edge; every later sample is one full
    // bit period after the previous one, which keeps all samples at mid-bit.
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          ODD_MODE  = 1'(PARITY_ODD);

    logic rxs;

    rx_state_t            state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 frame_done;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 hold_perr_q, hold_perr_d;
    logic                 hold_serr_q, hold_serr_d;
    logic                 overrun_q, overrun_d;
    logic                 accept;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d_i (RX_in),
        .q_o (rxs)
    );

    // Frame sequencing: everything advances only on oversample ticks, so rx_enb=0 freezes it.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        frame_done = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_enb && !rxs) begin
                    state_d = RX_START;
                    tick_d  = '0;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                end
            end
            RX_START: begin
                if (rx_enb) begin
                    if (tick_q == TICK_MID) begin
                        tick_d  = '0;
                        // A line that is high again at mid-start was a glitch, not a frame.
                        state_d = rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            RX_DATA: begin
                if (rx_enb) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (rx_enb) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        perr_d  = parity_mismatch(rxs, ^shreg_q, ODD_MODE);
                        state_d = RX_STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            RX_STOP: begin
                if (rx_enb) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d     = '0;
                        frame_done = 1'b1;
                        // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                        state_d    = rxs ? RX_IDLE : RX_BREAK;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            RX_BREAK: begin
                if (rx_enb && rxs) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // Frame sequencing state, counters and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
        end
    end

    assign accept = ready_q && rx_ready;

    // Holding register: a stalled consumer keeps its byte and the newer frame is dropped.
    always_comb begin
        data_d      = data_q;
        ready_d     = ready_q;
        hold_perr_d = hold_perr_q;
        hold_serr_d = hold_serr_q;
        overrun_d   = 1'b0;
        if (frame_done) begin
            if (ready_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                data_d      = shreg_q;
                ready_d     = 1'b1;
                hold_perr_d = perr_q;
                hold_serr_d = ~rxs;
            end
        end else if (accept) begin
            ready_d     = 1'b0;
            hold_perr_d = 1'b0;
            hold_serr_d = 1'b0;
        end
    end

    // Holding register and error flag storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q      <= '0;
            ready_q     <= 1'b0;
            hold_perr_q <= 1'b0;
            hold_serr_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            data_q      <= data_d;
            ready_q     <= ready_d;
            hold_perr_q <= hold_perr_d;
            hold_serr_q <= hold_serr_d;
            overrun_q   <= overrun_d;
        end
    end

    assign RX_data_out = data_q;
    assign data_ready  = ready_q;
    assign parity_err  = hold_perr_q;
    assign stop_err    = hold_serr_q;
    assign overrun_err = overrun_q;
    assign RX_busy     = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - scoreboard bench for uart_rx_oversample
module tb_uart_rx_oversample;

    localparam int OS         = 16;
    localparam int PARITY_ODD = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_in;
    logic       rx_enb;
    logic [7:0] RX_data_out;
    logic       data_ready;
    logic       rx_ready;
    logic       parity_err;
    logic       stop_err;
    logic       overrun_err;
    logic       RX_busy;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       serr;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   enb_div = 10;
    int   enb_cnt = 0;
    int   ovr_seen = 0;
    int   ovr_exp  = 0;

    uart_rx_oversample #(
        .DATA_BITS  (8),
        .OVERSAMPLE (OS),
        .PARITY_EN  (1),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX_in       (RX_in),
        .rx_enb      (rx_enb),
        .RX_data_out (RX_data_out),
        .data_ready  (data_ready),
        .rx_ready    (rx_ready),
        .parity_err  (parity_err),
        .stop_err    (stop_err),
        .overrun_err (overrun_err),
        .RX_busy     (RX_busy)
    );

    always #5 clk = ~clk;

    // Oversample tick: one pulse every enb_div clocks (every clock when enb_div == 1).
    initial begin
        rx_enb = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (enb_cnt >= enb_div - 1) begin
                enb_cnt = 0;
                rx_enb  = 1'b1;
            end else begin
                enb_cnt++;
                rx_enb = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a byte is consumed when the handshake is seen; compare it with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && data_ready && rx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h expected none at %0t", RX_data_out, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rx_data", 32'(RX_data_out), 32'(e.data));
                chk("parity_err", 32'(parity_err), 32'(e.perr));
                chk("stop_err", 32'(stop_err), 32'(e.serr));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && overrun_err) ovr_seen++;
    end

    function automatic logic ref_parity(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return logic'((ones % 2) ^ PARITY_ODD);
    endfunction

    function automatic int bit_clks();
        return OS * enb_div;
    endfunction

    task automatic drive_bit(input logic v);
        RX_in = v;
        repeat (bit_clks()) @(posedge clk);
        #3;
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    // Issue one frame; the reference model decides what the consumer should eventually see.
    // The holding register is one deep: a stalled consumer with a byte pending loses this frame.
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_v);
        exp_t e;
        e.data = d;
        e.perr = bad_par;
        e.serr = ~stop_v;
        if (!rx_ready && exp_q.size() > 0) ovr_exp++;
        else exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(ref_parity(d) ^ bad_par);
        drive_bit(stop_v);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_ready"}, 32'(data_ready), 0);
        chk({tag, "_rx_data"}, 32'(RX_data_out), 0);
        chk({tag, "_parity_err"}, 32'(parity_err), 0);
        chk({tag, "_stop_err"}, 32'(stop_err), 0);
        chk({tag, "_overrun"}, 32'(overrun_err), 0);
        chk({tag, "_busy"}, 32'(RX_busy), 0);
    endtask

    initial begin
        logic [7:0] d77;
        int         wait_cnt;
        rst      = 1'b1;
        RX_in    = 1'b1;
        rx_ready = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        chk_all_zero("reset");
        rst = 1'b0;
        idle_bits(1);

        // Basic frame.
        send_frame(8'hA5, 1'b0, 1'b1);
        idle_bits(2);

        // False start: low for 4 ticks only.
        RX_in = 1'b0;
        repeat (4 * enb_div) @(posedge clk);
        #3;
        chk("false_start_busy", 32'(RX_busy), 1);
        RX_in = 1'b1;
        repeat (20 * enb_div) @(posedge clk);
        #3;
        chk("false_start_idle", 32'(RX_busy), 0);

        // Parity error.
        send_frame(8'h3C, 1'b1, 1'b1);
        idle_bits(2);

        // Break: stop bit low and line held low for 3 bit times in total.
        send_frame(8'hF0, 1'b0, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        chk("break_busy", 32'(RX_busy), 1);
        idle_bits(2);
        chk("break_released", 32'(RX_busy), 0);
        send_frame(8'h81, 1'b0, 1'b1);
        idle_bits(2);

        // Overrun with a stalled consumer.
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1);
        idle_bits(1);
        send_frame(8'h22, 1'b0, 1'b1);
        idle_bits(2);
        chk("overrun_hold_data", 32'(RX_data_out), 32'h11);
        chk("overrun_hold_ready", 32'(data_ready), 1);
        chk("overrun_pulses", 32'(ovr_seen), 1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_cleared", 32'(data_ready), 0);
        idle_bits(1);

        // Reset in the middle of data bit 3.
        d77 = 8'h77;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d77[i]);
        RX_in = d77[3];
        repeat (bit_clks() / 2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("midframe_reset");
        RX_in = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        idle_bits(2);
        chk_all_zero("after_reset");
        send_frame(8'h5A, 1'b0, 1'b1);
        idle_bits(2);

        // Randomized frames at the nominal tick rate, then with a tick every clock.
        for (int pass = 0; pass < 2; pass++) begin
            enb_div = (pass == 0) ? 10 : 1;
            idle_bits(1);
            for (int n = 0; n < ((pass == 0) ? 8 : 24); n++) begin
                send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), 1'b1);
                idle_bits(int'($urandom_range(0, 2)));
            end
            idle_bits(2);
        end

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 2000) begin
            @(posedge clk);
            wait_cnt++;
        end
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        chk("overrun_total", 32'(ovr_seen), 32'(ovr_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
